// File: rtl/jimbo_bus_if.sv
// rtl/jimbo_bus_if.sv - jimbo CPU nibble bus: req/ack handshake, 12-bit address, 4-bit data
interface jimbo_bus_if;
  logic        bus_req;
  logic        bus_we;
  logic [11:0] bus_addr;
  logic [3:0]  bus_wdata;
  logic [3:0]  bus_rdata;
  logic        bus_ack;
  logic        bus_err;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_rdata,
    input  bus_ack,
    input  bus_err
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_rdata,
    output bus_ack,
    output bus_err
  );
endinterface

// File: rtl/jimbo_bus_target.sv
// rtl/jimbo_bus_target.sv - jimbo bus responder: nibble RAM window plus a small I/O page
// Four-phase req/ack with WAIT_STATES extra cycles between capture and ack.
module jimbo_bus_target #(
  parameter int          RAM_AW      = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [11:0] IO_BASE     = 12'hF00
) (
  input  logic       clk,
  input  logic       reset,
  jimbo_bus_if.slave bus,
  input  logic [3:0] io_in,
  output logic [3:0] io_out
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int          RAM_DEPTH = 1 << RAM_AW;
  localparam logic [11:0] RAM_LIMIT = 12'(RAM_DEPTH);
  localparam logic [3:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [11:0] IO_OUT_A  = IO_BASE;
  localparam logic [11:0] IO_IN_A   = IO_BASE + 12'd1;
  localparam logic [11:0] IO_TICK_A = IO_BASE + 12'd2;

  state_t      r_state;
  state_t      w_next_state;
  logic [3:0]  r_wait_cnt;
  logic        r_we;
  logic [11:0] r_addr;
  logic [3:0]  r_wdata;
  logic        r_ack;
  logic        r_err;
  logic [3:0]  r_rdata;
  logic [3:0]  r_tick;
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_io_out;
  logic [3:0]  r_mem [RAM_DEPTH];

  logic        w_capture;
  logic        w_commit;
  logic        w_release;
  logic        w_cur_we;
  logic [11:0] w_cur_addr;
  logic [3:0]  w_cur_wdata;
  logic        w_sel_ram;
  logic        w_sel_out;
  logic        w_sel_in;
  logic        w_sel_tick;
  logic        w_err;
  logic [3:0]  w_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (bus.bus_req) begin
          w_next_state = (WAIT_STATES == 0) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (r_wait_cnt == 4'd0) begin
          w_next_state = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!bus.bus_req) begin
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Output/control decode; with zero wait states capture and commit share an edge,
  // so the live bus is decoded while still in IDLE.
  always_comb begin
    w_capture   = (r_state == ST_IDLE) && bus.bus_req;
    w_commit    = (r_state != ST_ACK) && (w_next_state == ST_ACK);
    w_release   = (r_state == ST_ACK) && (w_next_state == ST_IDLE);
    w_cur_we    = (r_state == ST_IDLE) ? bus.bus_we    : r_we;
    w_cur_addr  = (r_state == ST_IDLE) ? bus.bus_addr  : r_addr;
    w_cur_wdata = (r_state == ST_IDLE) ? bus.bus_wdata : r_wdata;

    w_sel_ram  = (w_cur_addr < RAM_LIMIT);
    w_sel_out  = (w_cur_addr == IO_OUT_A);
    w_sel_in   = (w_cur_addr == IO_IN_A);
    w_sel_tick = (w_cur_addr == IO_TICK_A);

    w_err = !(w_sel_ram || w_sel_out || w_sel_in || w_sel_tick)
            || (w_cur_we && (w_sel_in || w_sel_tick));

    w_rdata = 4'd0;
    if (!w_cur_we) begin
      if (w_sel_ram) begin
        w_rdata = r_mem[w_cur_addr[RAM_AW-1:0]];
      end else if (w_sel_out) begin
        w_rdata = r_io_out;
      end else if (w_sel_in) begin
        w_rdata = r_sync2;
      end else if (w_sel_tick) begin
        w_rdata = r_tick;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_cnt <= 4'd0;
      r_we       <= 1'b0;
      r_addr     <= 12'd0;
      r_wdata    <= 4'd0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_rdata    <= 4'd0;
      r_tick     <= 4'd0;
      r_sync1    <= 4'd0;
      r_sync2    <= 4'd0;
      r_io_out   <= 4'd0;
    end else begin
      r_tick  <= r_tick + 4'd1;
      r_sync1 <= io_in;
      r_sync2 <= r_sync1;

      if (w_capture) begin
        r_we       <= bus.bus_we;
        r_addr     <= bus.bus_addr;
        r_wdata    <= bus.bus_wdata;
        r_wait_cnt <= WAIT_LOAD;
      end else if ((r_state == ST_WAIT) && (r_wait_cnt != 4'd0)) begin
        r_wait_cnt <= r_wait_cnt - 4'd1;
      end

      if (w_commit) begin
        r_ack   <= 1'b1;
        r_err   <= w_err;
        r_rdata <= w_rdata;
        if (w_cur_we && w_sel_out) begin
          r_io_out <= w_cur_wdata;
        end
      end else if (w_release) begin
        r_ack   <= 1'b0;
        r_err   <= 1'b0;
        r_rdata <= 4'd0;
      end
    end
  end

  // RAM contents survive reset; reset only blocks a commit on the same edge.
  always_ff @(posedge clk) begin
    if (!reset && w_commit && w_cur_we && w_sel_ram) begin
      r_mem[w_cur_addr[RAM_AW-1:0]] <= w_cur_wdata;
    end
  end

  assign bus.bus_ack   = r_ack;
  assign bus.bus_err   = r_err;
  assign bus.bus_rdata = r_rdata;
  assign io_out        = r_io_out;

endmodule

// File: tb/tb_jimbo_bus_target.sv
// tb/tb_jimbo_bus_target.sv - directed scoreboard bench for jimbo_bus_target (WAIT_STATES 1 and 3)
module tb_jimbo_bus_target;

  typedef struct {
    logic [3:0] rdata;
    logic       err;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst1;
  logic       rst3;
  logic [3:0] io_in;
  logic [3:0] io_out1;
  logic [3:0] io_out3;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  jimbo_bus_if b1 ();
  jimbo_bus_if b3 ();

  jimbo_bus_target #(.RAM_AW(8), .WAIT_STATES(1), .IO_BASE(12'hF00)) dut1 (
    .clk(clk), .reset(rst1), .bus(b1.slave), .io_in(io_in), .io_out(io_out1)
  );

  jimbo_bus_target #(.RAM_AW(8), .WAIT_STATES(3), .IO_BASE(12'hF00)) dut3 (
    .clk(clk), .reset(rst3), .bus(b3.slave), .io_in(io_in), .io_out(io_out3)
  );

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input int d, input logic req, input logic we,
                       input logic [11:0] a, input logic [3:0] wd);
    if (d == 1) begin
      b1.bus_req = req; b1.bus_we = we; b1.bus_addr = a; b1.bus_wdata = wd;
    end else begin
      b3.bus_req = req; b3.bus_we = we; b3.bus_addr = a; b3.bus_wdata = wd;
    end
  endtask

  function automatic logic ack_of(input int d);
    return (d == 1) ? b1.bus_ack : b3.bus_ack;
  endfunction

  function automatic logic err_of(input int d);
    return (d == 1) ? b1.bus_err : b3.bus_err;
  endfunction

  function automatic logic [3:0] rdata_of(input int d);
    return (d == 1) ? b1.bus_rdata : b3.bus_rdata;
  endfunction

  // One full handshake; bus inputs are scrambled during the hold to show capture is used.
  task automatic txn(input int d, input logic we, input logic [11:0] a, input logic [3:0] wd,
                     input logic [3:0] exp_rd, input logic exp_err, input int hold,
                     input string tag);
    exp_t e;
    int   lat;
    bit   got;
    e.rdata = exp_rd;
    e.err   = exp_err;
    drive(d, 1'b1, we, a, wd);
    sb_q.push_back(e);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 40) begin
      step();
      lat++;
      if (ack_of(d)) got = 1'b1;
    end
    check({tag, "_ack"}, 12'(got), 12'd1);
    e = sb_q.pop_front();
    if (got) begin
      check({tag, "_lat"}, 12'(lat), (d == 1) ? 12'd2 : 12'd4);
      check({tag, "_rdata"}, 12'(rdata_of(d)), 12'(e.rdata));
      check({tag, "_err"}, 12'(err_of(d)), 12'(e.err));
      if (hold > 0) drive(d, 1'b1, ~we, a ^ 12'h0AA, ~wd);
      for (int i = 0; i < hold; i++) begin
        step();
        check({tag, "_hold_ack"}, 12'(ack_of(d)), 12'd1);
        check({tag, "_hold_rdata"}, 12'(rdata_of(d)), 12'(e.rdata));
      end
    end
    drive(d, 1'b0, 1'b0, 12'h000, 4'h0);
    step();
    check({tag, "_ack_drop"}, 12'(ack_of(d)), 12'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    io_in = 4'h0;
    rst1  = 1'b1;
    rst3  = 1'b1;
    drive(1, 1'b1, 1'b1, 12'h005, 4'h3);
    drive(3, 1'b1, 1'b1, 12'h010, 4'h3);

    for (int i = 0; i < 2; i++) begin
      step();
      check("rst_ack", 12'(b1.bus_ack), 12'd0);
      check("rst_err", 12'(b1.bus_err), 12'd0);
      check("rst_rdata", 12'(b1.bus_rdata), 12'd0);
      check("rst_io_out", 12'(io_out1), 12'd0);
      check("rst_ack3", 12'(b3.bus_ack), 12'd0);
    end
    rst1 = 1'b0;
    rst3 = 1'b0;
    drive(1, 1'b0, 1'b0, 12'h000, 4'h0);
    drive(3, 1'b0, 1'b0, 12'h000, 4'h0);
    step();
    check("post_rst_no_capture", 12'(b1.bus_ack), 12'd0);
    step();
    check("post_rst_no_capture2", 12'(b1.bus_ack), 12'd0);

    // RAM round trip and held request
    txn(1, 1'b1, 12'h005, 4'hA, 4'h0, 1'b0, 0, "wr005");
    txn(1, 1'b0, 12'h005, 4'h0, 4'hA, 1'b0, 0, "rd005");
    txn(1, 1'b0, 12'h005, 4'h0, 4'hA, 1'b0, 5, "hold_rd005");

    // I/O page
    txn(1, 1'b1, 12'hF00, 4'h6, 4'h0, 1'b0, 0, "wr_io_out");
    check("io_out_val", 12'(io_out1), 12'h6);
    txn(1, 1'b0, 12'hF00, 4'h0, 4'h6, 1'b0, 0, "rd_io_out");
    io_in = 4'h9;
    step();
    step();
    txn(1, 1'b0, 12'hF01, 4'h0, 4'h9, 1'b0, 0, "rd_io_in");
    txn(1, 1'b1, 12'hF01, 4'h5, 4'h0, 1'b1, 0, "wr_io_in_err");
    check("io_out_kept", 12'(io_out1), 12'h6);
    txn(1, 1'b1, 12'hF02, 4'h5, 4'h0, 1'b1, 0, "wr_tick_err");

    // Unmapped addresses and aliasing
    txn(1, 1'b0, 12'h7FF, 4'h0, 4'h0, 1'b1, 0, "rd_unmapped");
    txn(1, 1'b0, 12'hF03, 4'h0, 4'h0, 1'b1, 0, "rd_past_io");
    txn(1, 1'b1, 12'h000, 4'h7, 4'h0, 1'b0, 0, "wr000");
    txn(1, 1'b1, 12'h023, 4'h1, 4'h0, 1'b0, 0, "wr023");
    txn(1, 1'b1, 12'h0FF, 4'hE, 4'h0, 1'b0, 0, "wr0ff");
    txn(1, 1'b1, 12'h123, 4'h3, 4'h0, 1'b1, 0, "wr123_err");
    txn(1, 1'b1, 12'h100, 4'h5, 4'h0, 1'b1, 0, "wr100_err");
    txn(1, 1'b0, 12'h000, 4'h0, 4'h7, 1'b0, 0, "rd000");
    txn(1, 1'b0, 12'h023, 4'h0, 4'h1, 1'b0, 0, "rd023");
    txn(1, 1'b0, 12'h0FF, 4'h0, 4'hE, 1'b0, 0, "rd0ff");

    // Request dropped before ack still completes with a one-cycle ack
    drive(1, 1'b1, 1'b1, 12'h030, 4'hC);
    step();
    drive(1, 1'b0, 1'b0, 12'h000, 4'h0);
    step();
    check("early_drop_ack", 12'(b1.bus_ack), 12'd1);
    check("early_drop_err", 12'(b1.bus_err), 12'd0);
    step();
    check("early_drop_ack_gone", 12'(b1.bus_ack), 12'd0);
    txn(1, 1'b0, 12'h030, 4'h0, 4'hC, 1'b0, 0, "rd030");

    // Reset clears io_out but keeps RAM
    rst1 = 1'b1;
    step();
    check("rst2_io_out", 12'(io_out1), 12'd0);
    rst1 = 1'b0;
    txn(1, 1'b0, 12'h005, 4'h0, 4'hA, 1'b0, 0, "rd005_after_rst");

    // WAIT_STATES=3: reset during WAIT discards the write
    txn(3, 1'b1, 12'h010, 4'h4, 4'h0, 1'b0, 0, "wr010_old");
    drive(3, 1'b1, 1'b1, 12'h010, 4'hF);
    step();
    step();
    rst3 = 1'b1;
    drive(3, 1'b0, 1'b0, 12'h000, 4'h0);
    step();
    check("rst_wait_ack", 12'(b3.bus_ack), 12'd0);
    rst3 = 1'b0;
    txn(3, 1'b0, 12'h010, 4'h0, 4'h4, 1'b0, 0, "rd010_discarded");

    // Back-to-back tick reads are 5 cycles apart: 8, 13, 2, 7, 12
    for (int i = 0; i < 5; i++) begin
      txn(3, 1'b0, 12'hF02, 4'h0, 4'((8 + 5 * i) % 16), 1'b0, 0, "rd_tick");
    end

    check("sb_empty", 12'(sb_q.size()), 12'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
